// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: filter state encoding,
// edge-select encoding and default geometry.
package input_conditioner_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILT_W      = 4;
    localparam logic [7:0]  GLITCH_MAX      = 8'hFF;

    // Bit 0 of every encoding is the accepted level, so signal_out is a plain flop output.
    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_HIGH      = 2'b01,
        ST_PEND_HIGH = 2'b10,
        ST_PEND_LOW  = 2'b11
    } filt_state_t;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_t;

    function automatic logic edge_selected(input logic [1:0] sel, input logic rising);
        logic hit;
        case (edge_sel_t'(sel))
            EDGE_RISE: hit = rising;
            EDGE_FALL: hit = !rising;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/input_conditioner_sync.sv
// Multi-flop synchronizer bringing an asynchronous pad signal into the clk domain.
module sync_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and deglitches an external level, strobes selected edges and
// counts rejected pulses.
module input_conditioner #(
    parameter int unsigned SYNC_STAGES = input_conditioner_pkg::DEF_SYNC_STAGES,
    parameter int unsigned FILT_W      = input_conditioner_pkg::DEF_FILT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [1:0]        edge_sel,
    input  logic              glitch_clr,
    output logic              signal_out,
    output logic              edge_pulse,
    output logic [7:0]        glitch_count
);

    import input_conditioner_pkg::*;

    filt_state_t       state, state_nxt;
    logic              sync_q;
    logic              differs;
    logic              commit;
    logic              glitch;
    logic              edge_nxt;
    logic [FILT_W-1:0] run_cnt, run_cnt_nxt;
    logic [FILT_W:0]   run_inc;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (signal_in),
        .q     (sync_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    assign differs = (sync_q != state[0]);
    assign run_inc = {1'b0, run_cnt} + {{FILT_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        commit      = 1'b0;
        glitch      = 1'b0;
        case (state)
            ST_LOW, ST_HIGH: begin
                if (differs) begin
                    if (filt_len == '0) begin
                        state_nxt = (state == ST_LOW) ? ST_HIGH : ST_LOW;
                        commit    = 1'b1;
                    end else begin
                        state_nxt   = (state == ST_LOW) ? ST_PEND_HIGH : ST_PEND_LOW;
                        run_cnt_nxt = '0;
                    end
                end
            end
            ST_PEND_HIGH, ST_PEND_LOW: begin
                if (differs) begin
                    // Compared against the live filt_len so a shortened filter commits at once.
                    if (run_inc >= {1'b0, filt_len}) begin
                        state_nxt = (state == ST_PEND_HIGH) ? ST_HIGH : ST_LOW;
                        commit    = 1'b1;
                    end else begin
                        run_cnt_nxt = run_inc[FILT_W-1:0];
                    end
                end else begin
                    state_nxt = (state == ST_PEND_HIGH) ? ST_LOW : ST_HIGH;
                    glitch    = 1'b1;
                end
            end
            default: state_nxt = ST_LOW;
        endcase
    end

    always_comb begin
        signal_out = state[0];
        edge_nxt   = commit && edge_selected(edge_sel, state_nxt[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt      <= '0;
            edge_pulse   <= 1'b0;
            glitch_count <= '0;
        end else begin
            run_cnt    <= run_cnt_nxt;
            edge_pulse <= edge_nxt;
            if (glitch_clr) begin
                glitch_count <= '0;
            end else if (glitch && glitch_count != GLITCH_MAX) begin
                glitch_count <= glitch_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-002 Parameter FILT_W, default 4, width of the filter-length control.
REQ-003 clk  input  1  system clock (wb_clk_i domain); the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 signal_in  input  1  raw asynchronous external signal (pad input).
REQ-006 filt_len  input  FILT_W  number of extra consecutive cycles a new level must persist before acceptance.
REQ-007 edge_sel  input  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 glitch_clr  input  1  single-cycle clear of glitch_count.
REQ-009 signal_out  output  1  synchronized, deglitched level, registered.
REQ-010 edge_pulse  output  1  one-cycle strobe on a selected edge of signal_out; feeds the frequency counter signal input.
REQ-011 glitch_count  output  8  saturating count of rejected pulses.

Function
REQ-012 signal_in SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is sync_q.
REQ-013 The filter SHALL be a four-state FSM: LOW, PEND_HIGH, HIGH, PEND_LOW; signal_out = 1 in HIGH and PEND_LOW, 0 otherwise.
REQ-014 In LOW/HIGH, sync_q differing from signal_out SHALL load run counter to 0 and move to PEND_HIGH/PEND_LOW; if filt_len = 0 the FSM SHALL go directly to HIGH/LOW instead.
REQ-015 In PEND_x, sync_q still differing SHALL increment run counter; when run counter + 1 >= filt_len the FSM SHALL commit to the new stable state (HIGH/LOW) that cycle.
REQ-016 In PEND_x, sync_q equal to signal_out SHALL return the FSM to the prior stable state and count one glitch.
REQ-017 Latency signal_in edge to signal_out change SHALL be exactly SYNC_STAGES + filt_len + 1 cycles.
REQ-018 A pulse on sync_q shorter than filt_len + 1 cycles SHALL not change signal_out.
REQ-019 edge_pulse SHALL be registered and high for exactly one cycle, the first cycle signal_out holds its new value, when the transition matches edge_sel; edge_sel = 00 SHALL hold it low.
REQ-020 glitch_count SHALL increment by 1 per REQ-016 event, saturate at 255, and not wrap.
REQ-021 glitch_clr SHALL zero glitch_count next cycle; clear coinciding with a glitch event SHALL yield 0 (clear wins).
REQ-022 filt_len changes SHALL take effect the next cycle; a pending run already >= new filt_len SHALL commit on the next differing cycle.
REQ-023 edge_sel changes SHALL affect only transitions committed after the change.
REQ-024 Run counter SHALL be FILT_W bits and never overflow (commit occurs at filt_len - 1 max).

Reset
REQ-025 reset SHALL clear all synchronizer flops, run counter, glitch_count, edge_pulse and signal_out to 0, FSM to LOW.
REQ-026 reset asserted mid-pending SHALL abandon the pending transition without counting a glitch or pulsing edge_pulse.
REQ-027 After reset release, a signal_in held high SHALL be accepted as a rising edge per REQ-017.

Structure
REQ-028 A shared package SHALL hold the filter state encoding, edge_sel encodings, and default SYNC_STAGES/FILT_W constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_chain, parameterized by depth, with synchronous active-high reset.
REQ-030 The wrapper SHALL drive signal_in from io_in[8] and route edge_pulse to the frequency counter; control inputs come from logic-analyzer bits.

Verification
REQ-031 filt_len=3, edge_sel=01, signal_in 0->1 held 20 cycles -> signal_out rises at cycle 6, single edge_pulse at cycle 6, glitch_count 0.
REQ-032 filt_len=3, 3-cycle high pulse -> signal_out stays 0, no edge_pulse, glitch_count = 1.
REQ-033 filt_len=0, edge_sel=11, 10-cycle-period square wave -> two edge_pulses per period, latency 3 cycles each.
REQ-034 300 glitch pulses, then glitch_clr coincident with a glitch -> count holds 255, then reads 0.
REQ-035 reset asserted 2 cycles into PEND_HIGH -> all outputs 0 next cycle, no edge_pulse, glitch_count 0.
REQ-036 filt_len lowered 8->2 while run counter = 5 -> commit on next differing cycle, one edge_pulse.
